// File: rtl/bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// bit_serializer_pkg
//   Shared types and helpers for the parallel-to-serial stage.
//   - ser_state_e : shifter FSM states (PAR is only reachable when the
//                   SER_PARITY_EN macro is defined)
//   - frame_w()   : serial frame length in bits for a given word width
// Configuration macro: SER_PARITY_EN (appends one even-parity bit per word).
// -----------------------------------------------------------------------------
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } ser_state_e;

  // Number of serial bits emitted per accepted word.
  function automatic int unsigned frame_w(input int unsigned data_w);
`ifdef SER_PARITY_EN
    return data_w + 1;
`else
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/bit_serializer_hold_buf.sv
// -----------------------------------------------------------------------------
// ser_hold_buf
//   One-entry valid/ready holding buffer in front of the shifter. The entry
//   can be drained (i_load) and refilled by a new accept on the same edge, so
//   back-to-back words stream without a bubble.
// Ports:
//   clk, resetn  : rising-edge clock, asynchronous active-low reset
//   i_data       : parallel word from upstream
//   i_valid      : i_data valid
//   i_load       : shifter takes the buffered word this cycle
//   o_ready      : buffer can accept this cycle (registered state only)
//   o_buf_valid  : buffer holds a word
//   o_buf_data   : buffered word
// -----------------------------------------------------------------------------
module ser_hold_buf
  import bit_serializer_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_load,
  output logic              o_ready,
  output logic              o_buf_valid,
  output logic [DATA_W-1:0] o_buf_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              w_accept;

  // Ready depends only on registered state and i_load (itself derived from
  // registered state), never on i_valid.
  assign o_ready  = !r_valid || i_load;
  assign w_accept = i_valid && o_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
    end else if (i_load) begin
      r_valid <= 1'b0;
    end
  end

  // NOTE: the data word is qualified by r_valid, so it needs no reset; only
  // the valid flag is reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data <= i_data;
    end
  end

  assign o_buf_valid = r_valid;
  assign o_buf_data  = r_data;

endmodule

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Parallel-to-serial stage feeding a bit-serial detector. Words arrive over
//   valid/ready into a one-entry holding buffer and are shifted out one bit
//   per clock, back-to-back without idle gaps.
// Parameters:
//   DATA_W    : word width (>= 2)
//   LSB_FIRST : 0 sends bit DATA_W-1 first, 1 sends bit 0 first
//   IDLE_BIT  : ser_out level while no frame is being shifted
// Ports:
//   clk, resetn : rising-edge clock, asynchronous active-low reset
//   in_data     : parallel word
//   in_valid    : in_data valid
//   in_ready    : a word is taken when in_valid && in_ready at clk
//   ser_out     : serial bit, driven straight from a flop
//   ser_valid   : ser_out carries a frame bit
//   frame_done  : high with the last bit of each frame
//   busy        : frame in flight or word buffered
// Configuration macro: SER_PARITY_EN - appends an even-parity bit (XOR of the
//   data bits) after each word and enables the PAR state.
// Timing: a word accepted in cycle C with the shifter idle shows its first
//   bit in cycle C+2 (buffer, then shifter load).
// -----------------------------------------------------------------------------
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          LSB_FIRST = 1'b0,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned      FRAME_W    = frame_w(DATA_W);
  localparam int unsigned      CNT_W      = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FRAME_W - 1);

  ser_state_e        r_state,  w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
  logic [DATA_W-1:0] r_shift,  w_shift_nxt;
  logic              r_ser_out, w_ser_nxt;
`ifdef SER_PARITY_EN
  logic              r_par,    w_par_nxt;
`endif

  logic              w_buf_valid;
  logic [DATA_W-1:0] w_buf_data;
  logic              w_load;
  logic              w_last_bit;
  logic              w_first_bit;
  logic [DATA_W-1:0] w_first_rest;
  logic              w_next_bit;
  logic [DATA_W-1:0] w_shift_adv;

  ser_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold_buf (
    .clk         (clk),
    .resetn      (resetn),
    .i_data      (in_data),
    .i_valid     (in_valid),
    .i_load      (w_load),
    .o_ready     (in_ready),
    .o_buf_valid (w_buf_valid),
    .o_buf_data  (w_buf_data)
  );

  // Final bit of the frame currently on ser_out.
`ifdef SER_PARITY_EN
  assign w_last_bit = (r_state == PAR);
`else
  assign w_last_bit = (r_state == SHIFT) && (r_cnt == LAST_FRAME);
`endif

  // Shifter takes the buffered word when idle or while the previous frame's
  // last bit is out, which keeps consecutive frames gapless.
  assign w_load = w_buf_valid && ((r_state == IDLE) || w_last_bit);

  // The first bit goes straight into the ser_out flop on load; the shift
  // register then holds the remaining bits aligned to the outgoing end.
  assign w_first_bit  = LSB_FIRST ? w_buf_data[0] : w_buf_data[DATA_W-1];
  assign w_first_rest = LSB_FIRST ? (w_buf_data >> 1) : (w_buf_data << 1);
  assign w_next_bit   = LSB_FIRST ? r_shift[0] : r_shift[DATA_W-1];
  assign w_shift_adv  = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_ser_nxt   = r_ser_out;
`ifdef SER_PARITY_EN
    w_par_nxt   = r_par;
`endif

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_ser_nxt = IDLE_BIT;
      end
      SHIFT: begin
        if (r_cnt == LAST_DATA) begin
`ifdef SER_PARITY_EN
          w_state_nxt = PAR;
          w_cnt_nxt   = LAST_FRAME;
          w_ser_nxt   = r_par;
`else
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_ser_nxt   = IDLE_BIT;
`endif
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_ser_nxt   = w_next_bit;
          w_shift_nxt = w_shift_adv;
        end
      end
`ifdef SER_PARITY_EN
      PAR: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_ser_nxt   = IDLE_BIT;
      end
`endif
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_ser_nxt   = IDLE_BIT;
      end
    endcase

    // A load overrides the end-of-frame return to IDLE.
    if (w_load) begin
      w_state_nxt = SHIFT;
      w_cnt_nxt   = '0;
      w_ser_nxt   = w_first_bit;
      w_shift_nxt = w_first_rest;
`ifdef SER_PARITY_EN
      w_par_nxt   = ^w_buf_data;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_ser_out <= IDLE_BIT;
`ifdef SER_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ser_out <= w_ser_nxt;
`ifdef SER_PARITY_EN
      r_par     <= w_par_nxt;
`endif
    end
  end

  assign ser_out    = r_ser_out;
  assign ser_valid  = (r_state != IDLE);
  assign frame_done = w_last_bit;
  assign busy       = ser_valid || w_buf_valid;

endmodule
